// File: rtl/pc_sequencer.sv
// Next-PC controller with a four-state run/stall/trap/halt sequencer.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned redirect target traps).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080,
    parameter int unsigned STEP        = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        JrEn,
    input  logic [31:0] JrTarget,
    input  logic        Trap,
    input  logic        Eret,
    input  logic        Halt,
    input  logic [31:0] PCin,
    output logic [31:0] PCnext,
    output logic [31:0] EPC,
    output logic [1:0]  Cause,
    output logic        Flush,
    output logic        Halted,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        TRAP  = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_MISA = 2'b01;
    localparam logic [1:0] CAUSE_EXT  = 2'b10;

    state_t      state_q, state_n;
    logic [31:0] epc_q, epc_n;
    logic [1:0]  cause_q, cause_n;
    logic [31:0] seq_pc;
    logic [31:0] redir_tgt;
    logic        redir;

    assign seq_pc = PCin + 32'(STEP);

    // Highest-priority taken redirect and its target
    always_comb begin
        redir     = 1'b0;
        redir_tgt = seq_pc;
        if (JrEn) begin
            redir     = 1'b1;
            redir_tgt = JrTarget;
        end else if (Jump) begin
            redir     = 1'b1;
            redir_tgt = JumpTarget;
        end else if (BranchTaken) begin
            redir     = 1'b1;
            redir_tgt = BranchTarget;
        end
    end

    // Next-PC select, flush strobe and next FSM/trap-register values
    always_comb begin
        state_n = state_q;
        epc_n   = epc_q;
        cause_n = cause_q;
        PCnext  = seq_pc;
        Flush   = 1'b0;
        case (state_q)
            TRAP: begin
                PCnext  = PCin;
                state_n = RUN;
            end
            HALT: begin
                if (Trap) begin
                    PCnext  = TRAP_VECTOR;
                    Flush   = 1'b1;
                    epc_n   = PCin;
                    cause_n = CAUSE_EXT;
                    state_n = TRAP;
                end else begin
                    PCnext = PCin;
                end
            end
            default: begin
                state_n = RUN;
                if (Trap) begin
                    PCnext  = TRAP_VECTOR;
                    Flush   = 1'b1;
                    epc_n   = PCin;
                    cause_n = CAUSE_EXT;
                    state_n = TRAP;
                end else if (Eret) begin
                    PCnext  = epc_q;
                    Flush   = 1'b1;
                    cause_n = CAUSE_NONE;
                end else if (Halt) begin
                    PCnext  = PCin;
                    state_n = HALT;
                end else if (Stall) begin
                    PCnext  = PCin;
                    state_n = STALL;
                end else if (redir) begin
                    PCnext = redir_tgt;
                    Flush  = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                    if (redir_tgt[1:0] != 2'b00) begin
                        PCnext  = TRAP_VECTOR;
                        epc_n   = PCin;
                        cause_n = CAUSE_MISA;
                        state_n = TRAP;
                    end
`endif
                end
            end
        endcase
        if (Reset) begin
            PCnext = RESET_PC;
            Flush  = 1'b0;
        end
    end

    // FSM and trap registers update on the falling edge with the PC register
    always_ff @(negedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
            epc_q   <= 32'h0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_n;
            epc_q   <= epc_n;
            cause_q <= cause_n;
        end
    end

    assign EPC    = epc_q;
    assign Cause  = cause_q;
    assign State  = state_q;
    assign Halted = (state_q == HALT);

endmodule
